// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, load-use/redirect hazards and data-memory
// handshake stalls for the five-stage core, with a saturating stall counter.
module hazard_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  RdD,
   input  logic [2:0]  ResultSrcE,
   input  logic [1:0]  PCSrcE,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        MemAccessM,
   input  logic        DMemReadyM,
   output logic        DMemReqM,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        StallW,
   output logic        FlushD,
   output logic        FlushE,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic [15:0] StallCount
);
   typedef enum logic {S_RUN, S_WAIT} state_t;
   state_t state, state_nx;
   logic [4:0] Rs1E, Rs2E, RdE, RdM, RdW;
   logic lw_stall, mem_stall, redirect;
   always_comb begin
      lw_stall  = ResultSrcE == 3'b001 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
      redirect  = PCSrcE[0];
      mem_stall = !DMemReadyM && (state == S_WAIT || MemAccessM);
      state_nx  = mem_stall ? S_WAIT : S_RUN;
      DMemReqM  = state == S_RUN && MemAccessM;
      // a memory stall freezes everything, so pending flushes wait for it to clear
      StallF    = mem_stall || lw_stall;
      StallD    = StallF;
      StallE    = mem_stall;
      StallM    = mem_stall;
      StallW    = mem_stall;
      FlushD    = !mem_stall && redirect;
      FlushE    = !mem_stall && (lw_stall || redirect);
      ForwardAE = Rs1E == 5'd0 ? 2'b00 :
                  RegWriteM && RdM == Rs1E ? 2'b10 :
                  RegWriteW && RdW == Rs1E ? 2'b01 : 2'b00;
      ForwardBE = Rs2E == 5'd0 ? 2'b00 :
                  RegWriteM && RdM == Rs2E ? 2'b10 :
                  RegWriteW && RdW == Rs2E ? 2'b01 : 2'b00;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         {Rs1E, Rs2E, RdE, RdM, RdW} <= '0;
         state      <= S_RUN;
         StallCount <= '0;
      end else begin
         if (FlushE) {Rs1E, Rs2E, RdE} <= '0;
         else if (!StallE) {Rs1E, Rs2E, RdE} <= {Rs1D, Rs2D, RdD};
         if (!StallM) RdM <= RdE;
         if (!StallW) RdW <= RdM;
         state <= state_nx;
         if (StallF && StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
      end
   end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vector table, hand sequences for the memory
// handshake/reset/saturation, and random stimulus against a rule-level model.
module tb_hazard_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic [2:0]  ResultSrcE;
   logic [1:0]  PCSrcE;
   logic        RegWriteM, RegWriteW, MemAccessM, DMemReadyM;
   logic        DMemReqM, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [15:0] StallCount;
   int n_cmp = 0;
   int n_bad = 0;

   hazard_unit dut (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .MemAccessM(MemAccessM), .DMemReadyM(DMemReadyM),
      .DMemReqM(DMemReqM), .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .StallM(StallM), .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCount(StallCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  rsrc;
      logic [1:0]  pc;
      logic        rwm, rww, mem, rdy;
      logic [27:0] exp;
   } vec_t;

   // packed observation: {req, F,D,E,M,W stalls, FlushD, FlushE, fwdA, fwdB, count}
   function automatic logic [27:0] pk(input logic req, input logic [4:0] st, input logic fd,
                                      input logic fe, input logic [1:0] fa, input logic [1:0] fb,
                                      input int cnt);
      return {req, st, fd, fe, fa, fb, 16'(cnt)};
   endfunction

   function automatic vec_t mv(input int rs1, input int rs2, input int rd, input int rsrc,
                               input int pc, input bit rwm, input bit rww, input bit mem,
                               input bit rdy, input logic [27:0] exp);
      vec_t v;
      v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd); v.rsrc = 3'(rsrc); v.pc = 2'(pc);
      v.rwm = rwm; v.rww = rww; v.mem = mem; v.rdy = rdy; v.exp = exp;
      return v;
   endfunction

   function automatic logic [27:0] obs();
      return {DMemReqM, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
              ForwardAE, ForwardBE, StallCount};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd; ResultSrcE = v.rsrc; PCSrcE = v.pc;
      RegWriteM = v.rwm; RegWriteW = v.rww; MemAccessM = v.mem; DMemReadyM = v.rdy;
   endtask

   // reference model: instruction register numbers flowing through E/M/W
   int m_e[3];
   int m_rdm, m_rdw, m_cnt;
   bit m_busy;

   function automatic logic [1:0] fwd(input int rs);
      if (rs == 0) return 2'b00;
      if (RegWriteM && m_rdm == rs) return 2'b10;
      if (RegWriteW && m_rdw == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_e = '{0, 0, 0}; m_rdm = 0; m_rdw = 0; m_cnt = 0; m_busy = 0;
   endtask

   task automatic model_step(output logic [27:0] e);
      bit ms, lw, red, sf;
      int old_rde, old_rdm;
      ms  = !DMemReadyM && (m_busy || MemAccessM);
      lw  = ResultSrcE == 3'b001 && m_e[2] != 0 && (m_e[2] == int'(Rs1D) || m_e[2] == int'(Rs2D));
      red = PCSrcE[0];
      sf  = ms || lw;
      e = pk(!m_busy && MemAccessM, {sf, sf, ms, ms, ms}, !ms && red, !ms && (lw || red),
             fwd(m_e[0]), fwd(m_e[1]), m_cnt);
      old_rde = m_e[2];
      old_rdm = m_rdm;
      if (!ms && (lw || red)) m_e = '{0, 0, 0};
      else if (!ms) m_e = '{int'(Rs1D), int'(Rs2D), int'(RdD)};
      if (!ms) begin
         m_rdm = old_rde;
         m_rdw = old_rdm;
      end
      m_busy = ms;
      if (sf && m_cnt < 65535) m_cnt++;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      drive(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   vec_t tbl[17];
   logic [27:0] e;
   int reqs, stalls;

   initial begin
      tbl[0]  = mv(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
      tbl[1]  = mv(0, 0, 5, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
      tbl[2]  = mv(0, 0, 5, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
      tbl[3]  = mv(5, 0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
      tbl[4]  = mv(0, 5, 0, 0, 0, 1, 1, 0, 0, pk(0, 0, 0, 0, 2'b10, 0, 0));
      tbl[5]  = mv(0, 0, 7, 0, 0, 1, 1, 0, 0, pk(0, 0, 0, 0, 0, 2'b01, 0));
      tbl[6]  = mv(0, 7, 3, 1, 0, 0, 0, 0, 0, pk(0, 5'b11000, 0, 1, 0, 0, 0));
      tbl[7]  = mv(0, 7, 3, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 1));
      tbl[8]  = mv(1, 2, 4, 0, 1, 0, 1, 0, 0, pk(0, 0, 1, 1, 0, 2'b01, 1));
      tbl[9]  = mv(0, 0, 0, 0, 0, 1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 1));
      tbl[10] = mv(0, 0, 0, 0, 0, 0, 0, 1, 1, pk(1, 0, 0, 0, 0, 0, 1));
      tbl[11] = mv(0, 0, 0, 0, 0, 0, 0, 1, 0, pk(1, 5'h1f, 0, 0, 0, 0, 1));
      tbl[12] = mv(0, 0, 0, 0, 1, 0, 0, 1, 0, pk(0, 5'h1f, 0, 0, 0, 0, 2));
      tbl[13] = mv(0, 0, 0, 0, 1, 0, 0, 1, 1, pk(0, 0, 1, 1, 0, 0, 3));
      tbl[14] = mv(0, 0, 0, 0, 0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 3));
      tbl[15] = mv(0, 0, 0, 0, 0, 0, 0, 1, 1, pk(1, 0, 0, 0, 0, 0, 3));
      tbl[16] = mv(0, 0, 0, 0, 0, 0, 0, 1, 1, pk(1, 0, 0, 0, 0, 0, 3));

      reset = 1'b1;
      drive(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
      do_reset();
      chk("reset_state", 32'(obs()), 32'(0));
      foreach (tbl[i]) begin
         drive(tbl[i]);
         #2 chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
         @(posedge clk);
         #1;
      end

      // three-cycle memory wait: one request pulse, three stall cycles
      do_reset();
      reqs = 0; stalls = 0;
      for (int i = 0; i < 4; i++) begin
         drive(mv(0, 0, 0, 0, 0, 0, 0, 1, i == 3, '0));
         #2;
         reqs += int'(DMemReqM);
         stalls += int'(StallF && StallD && StallE && StallM && StallW);
         @(posedge clk);
         #1;
      end
      chk("mem_req_pulses", 32'(reqs), 32'd1);
      chk("mem_stall_cycles", 32'(stalls), 32'd3);
      chk("mem_stall_count", 32'(StallCount), 32'd3);
      drive(mv(0, 0, 0, 0, 0, 0, 0, 1, 1, '0));
      #2 chk("mem_back_in_run", 32'({DMemReqM, StallF}), 32'b10);
      @(posedge clk);

      // asynchronous reset while waiting on memory
      #1 drive(mv(0, 0, 0, 0, 0, 0, 0, 1, 0, '0));
      @(posedge clk);
      #1 chk("wait_entered", 32'({DMemReqM, StallE}), 32'b01);
      #2 MemAccessM = 1'b0;
      reset = 1'b0;
      #1 chk("async_reset", 32'(obs()), 32'(0));
      @(posedge clk);
      #1 reset = 1'b1;
      MemAccessM = 1'b1;
      #1 chk("run_after_reset", 32'({DMemReqM, StallF}), 32'b11);

      // randomized run against the model
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         Rs1D = 5'($urandom_range(0, 3));
         Rs2D = 5'($urandom_range(0, 3));
         RdD  = 5'($urandom_range(0, 3));
         ResultSrcE = $urandom_range(0, 2) == 0 ? 3'b001 : 3'($urandom_range(0, 7));
         PCSrcE = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0)};
         RegWriteM  = 1'($urandom_range(0, 1));
         RegWriteW  = 1'($urandom_range(0, 1));
         MemAccessM = $urandom_range(0, 9) < 3;
         DMemReadyM = 1'($urandom_range(0, 1));
         #2 model_step(e);
         chk($sformatf("rand%0d", i), 32'(obs()), 32'(e));
         @(posedge clk);
         #1;
      end

      // counter saturation
      do_reset();
      drive(mv(0, 0, 0, 0, 0, 0, 0, 1, 0, '0));
      repeat (65540) @(posedge clk);
      #1 chk("count_saturated", 32'(StallCount), 32'hFFFF);
      @(posedge clk);
      #1 chk("count_holds", 32'(StallCount), 32'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
